div_int_issue: RTL and testbench

Issue/retire stage that sits directly upstream of `div_int` and connects it to the pipeline. It accepts one divide request at a time over a valid/ready handshake and latches the operands. It pulses `div_int` and holds the operands stable for the whole computation, then captures the quotient and remainder into a result register that drains through a valid/ready handshake. Divide-by-zero and signed overflow are resolved locally in one cycle, without starting `div_int`.

---
 rtl/div_int_issue.sv | 123 ++++++++++++
 tb/tb_div_int_issue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_int_issue.sv
// Issue/retire stage in front of div_int: accepts one divide request, launches div_int,
// and presents quotient/remainder/tag through a valid/ready result register.
module div_int_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_opcode,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  div_en,
  output logic                  div_opcode,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_valid_out,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0] out_remainder,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_opcode;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_div_en;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_zero;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_min_neg;

  assign w_min_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Retiring a held result and accepting the next request may share one edge.
  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_zero   = (in_divisor == '0);
  assign w_ovf    = in_opcode && (in_dividend == w_min_neg) && (in_divisor == {DATA_WIDTH{1'b1}});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_opcode    <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_tag       <= '0;
      r_div_en    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_div_en <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_opcode   <= in_opcode;
            r_dividend <= in_dividend;
            r_divisor  <= in_divisor;
            r_tag      <= in_tag;
            if (w_zero) begin
              r_quotient  <= '1;
              r_remainder <= in_dividend;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_ovf) begin
              r_quotient  <= in_dividend;
              r_remainder <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_div_en    <= 1'b1;
              r_out_valid <= 1'b0;
              r_state     <= ISSUE;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // Pulses arriving in any other state are deliberately ignored.
          if (div_valid_out) begin
            r_quotient  <= div_quotient;
            r_remainder <= div_remainder;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_en        = r_div_en;
  assign div_opcode    = r_opcode;
  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign out_valid     = r_out_valid;
  assign out_quotient  = r_quotient;
  assign out_remainder = r_remainder;
  assign out_tag       = r_tag;

endmodule

// File: tb/tb_div_int_issue.sv
// Bench for div_int_issue: behavioural div_int model plus scoreboard of expected results.
module tb_div_int_issue;

  localparam int DW = 32;
  localparam int TW = 4;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_opcode;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          div_en;
  logic          div_opcode;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_valid_out;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic [DW-1:0] out_remainder;
  logic [TW-1:0] out_tag;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  div_int_issue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .div_en(div_en), .div_opcode(div_opcode),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_out(div_valid_out), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural div_int: samples en, answers with a one-cycle valid pulse DW+2 edges later.
  int            m_cnt;
  logic          m_op;
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  int            en_cnt       = 0;
  int            unstable_cnt = 0;

  function automatic logic [DW-1:0] model_q(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op) return DW'($signed(a) / $signed(b));
    return a / b;
  endfunction

  function automatic logic [DW-1:0] model_r(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op) return DW'($signed(a) % $signed(b));
    return a % b;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt         <= 0;
      div_valid_out <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_valid_out <= 1'b0;
      if (div_en) begin
        en_cnt <= en_cnt + 1;
        m_cnt  <= DW + 2;
        m_op   <= div_opcode;
        m_a    <= div_dividend;
        m_b    <= div_divisor;
      end else if (m_cnt != 0) begin
        if (div_opcode !== m_op || div_dividend !== m_a || div_divisor !== m_b)
          unstable_cnt <= unstable_cnt + 1;
        if (m_cnt == 1) begin
          div_valid_out <= 1'b1;
          div_quotient  <= model_q(m_op, m_a, m_b);
          div_remainder <= model_r(m_op, m_a, m_b);
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag, output bit acc);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = tag;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = in_ready;
      @(negedge clock);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, out_valid, div_en} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: got in_ready/out_valid/div_en=%b want 100", {in_ready, out_valid, div_en});
    end
    checks++;
    if ({out_quotient, out_remainder, out_tag, div_dividend, div_divisor} !== '0) begin
      failures++;
      $display("FAIL reset_regs: got q=%h r=%h tag=%h want all zero", out_quotient, out_remainder, out_tag);
    end
  endtask

  task automatic test_unsigned;
    bit acc; int n; int en0; int un0; exp_t e;
    sb.push_back('{q: 32'd14, r: 32'd2, tag: 4'h3});
    en0 = en_cnt; un0 = unstable_cnt;
    send(1'b0, 32'd100, 32'd7, 4'h3, acc);
    checks++;
    if (!acc) begin failures++; $display("FAIL unsigned_accept: got %0b want 1", acc); end
    wait_out(n);
    checks++;
    if (n != 36) begin failures++; $display("FAIL unsigned_latency: got %0d want 36", n); end
    e = sb.pop_front();
    checks++;
    if ({out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL unsigned_result: got q=%h r=%h tag=%h want q=%h r=%h tag=%h",
               out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    checks++;
    if (en_cnt - en0 != 1) begin failures++; $display("FAIL unsigned_div_en: got %0d cycles want 1", en_cnt - en0); end
    checks++;
    if (unstable_cnt != un0) begin failures++; $display("FAIL unsigned_operand_stable: got %0d changes want 0", unstable_cnt - un0); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL unsigned_retire: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_signed;
    logic [DW-1:0] a_tab[2];
    logic [DW-1:0] b_tab[2];
    bit acc; int n; exp_t e;
    a_tab[0] = -32'sd100; b_tab[0] = 32'd7;
    a_tab[1] = 32'd100;   b_tab[1] = -32'sd7;
    sb.push_back('{q: 32'hFFFF_FFF2, r: 32'hFFFF_FFFE, tag: 4'h5});
    sb.push_back('{q: 32'hFFFF_FFF2, r: 32'd2,         tag: 4'h6});
    for (int k = 0; k < 2; k++) begin
      send(1'b1, a_tab[k], b_tab[k], TW'(5 + k), acc);
      wait_out(n);
      e = sb.pop_front();
      checks++;
      if (n != 36 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
        failures++;
        $display("FAIL signed_%0d: got lat=%0d q=%h r=%h tag=%h want lat=36 q=%h r=%h tag=%h",
                 k, n, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_zero_divisor;
    bit acc; int n; int en0; exp_t e;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{q: 32'hFFFF_FFFF, r: 32'h0000_1234, tag: TW'(8 + k)});
      en0 = en_cnt;
      send(k[0], 32'h1234, 32'd0, TW'(8 + k), acc);
      wait_out(n);
      e = sb.pop_front();
      checks++;
      if (n != 0 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
        failures++;
        $display("FAIL zero_div_%0d: got lat=%0d q=%h r=%h tag=%h want lat=0 q=%h r=%h tag=%h",
                 k, n, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
      end
      checks++;
      if (en_cnt != en0) begin failures++; $display("FAIL zero_div_en_%0d: got %0d pulses want 0", k, en_cnt - en0); end
      @(negedge clock);
    end
  endtask

  task automatic test_overflow;
    bit acc; int n; int en0; exp_t e;
    sb.push_back('{q: 32'h8000_0000, r: 32'd0, tag: 4'hB});
    en0 = en_cnt;
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, acc);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (n != 0 || en_cnt != en0 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL overflow_signed: got lat=%0d en=%0d q=%h r=%h tag=%h want lat=0 en=0 q=%h r=%h tag=%h",
               n, en_cnt - en0, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    @(negedge clock);
    sb.push_back('{q: 32'd0, r: 32'h8000_0000, tag: 4'hC});
    send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hC, acc);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (n != 36 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL overflow_unsigned: got lat=%0d q=%h r=%h tag=%h want lat=36 q=%h r=%h tag=%h",
               n, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    bit acc; int n; int bad; exp_t e;
    out_ready = 1'b0;
    sb.push_back('{q: 32'd10, r: 32'd3, tag: 4'h7});
    send(1'b0, 32'd53, 32'd5, 4'h7, acc);
    wait_out(n);
    sb.push_back('{q: 32'hFFFF_FFFF, r: 32'h55, tag: 4'hD});
    e = sb[0];
    in_valid = 1'b1; in_opcode = 1'b0; in_dividend = 32'h55; in_divisor = 32'd0; in_tag = 4'hD;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold: got %0d bad cycles (q=%h r=%h tag=%h) want 0", bad, out_quotient, out_remainder, out_tag);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL backpressure_ready: got in_ready=%b want 1", in_ready); end
    e = sb.pop_front();
    checks++;
    if ({out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL backpressure_first: got q=%h r=%h tag=%h want q=%h r=%h tag=%h",
               out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    @(negedge clock);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL backpressure_second: got v=%b q=%h r=%h tag=%h want v=1 q=%h r=%h tag=%h",
               out_valid, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int bad; exp_t e;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{q: 32'hFFFF_FFFF, r: DW'(32'h100 + k), tag: TW'(k)});
      in_valid = 1'b1; in_opcode = k[0]; in_dividend = DW'(32'h100 + k); in_divisor = 32'd0; in_tag = TW'(k);
      #1;
      if (in_ready !== 1'b1) bad++;
      @(negedge clock);
      e = sb.pop_front();
      if (out_valid !== 1'b1 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL back_to_back: got %0d bad cycles want 0", bad); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    bit acc; int n; exp_t e;
    send(1'b0, 32'd1000, 32'd3, 4'h2, acc);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, div_en} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_ctrl: got in_ready/out_valid/div_en=%b want 100", {in_ready, out_valid, div_en});
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.push_back('{q: 32'd3, r: 32'd0, tag: 4'hA});
    send(1'b0, 32'd9, 32'd3, 4'hA, acc);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (n != 36 || {out_quotient, out_remainder, out_tag} !== {e.q, e.r, e.tag}) begin
      failures++;
      $display("FAIL reset_mid_next: got lat=%0d q=%h r=%h tag=%h want lat=36 q=%h r=%h tag=%h",
               n, out_quotient, out_remainder, out_tag, e.q, e.r, e.tag);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_opcode = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_unsigned();
    test_signed();
    test_zero_divisor();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
